// File: rtl/rpn_pkg.sv
// Shared constants and types for the RPN calculator controller.
package rpn_pkg;

  localparam int DW = 8;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DROP = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    POP_B,
    POP_A,
    EXEC,
    WAIT,
    PUSH
  } state_t;

endpackage

// File: rtl/rpn_ctrl_if.sv
// Stack and ALU handshake bundle between the controller and the datapath.
interface rpn_ctrl_if #(
  parameter int CW = 4
);
  import rpn_pkg::*;

  // Operand stack
  logic [DW-1:0] stk_rdata;
  logic [CW-1:0] stk_count;
  logic          stk_push;
  logic          stk_pop;
  logic [DW-1:0] stk_wdata;

  // Multi-cycle ALU
  logic          alu_start;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_done;
  logic [DW-1:0] alu_result;
  logic          alu_ovf;

  modport master (
    input  stk_rdata, stk_count, alu_done, alu_result, alu_ovf,
    output stk_push, stk_pop, stk_wdata, alu_start, alu_op, alu_a, alu_b
  );

  modport slave (
    output stk_rdata, stk_count, alu_done, alu_result, alu_ovf,
    input  stk_push, stk_pop, stk_wdata, alu_start, alu_op, alu_a, alu_b
  );

endinterface

// File: rtl/rpn_key_edge.sv
// Pushbutton conditioner: 2-flop synchroniser followed by a registered
// falling-edge detector. One evt pulse per press, 3 cycles after the edge.
module rpn_key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic evt
);

  logic [1:0] sync;
  logic       prev;

  // Synchronise the raw button and flag a high-to-low transition.
  // Clearing to 0 means a button already released at reset looks like a
  // rising edge, so no spurious event is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
      prev <= 1'b0;
      evt  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its neighbour, which is what turns this into a shift chain.
      sync <= {sync[0], key_n};
      prev <= sync[1];
      evt  <= prev & ~sync[1];
    end
  end

endmodule

// File: rtl/rpn_ctrl.sv
// RPN calculator sequencer: turns button events into stack pushes/pops and
// runs pop-pop-execute-push sequences against a multi-cycle ALU.
module rpn_ctrl
  import rpn_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int CW          = 4,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          enter_n,
  input  logic          op_n,
  input  logic [DW-1:0] sw,
  input  logic [1:0]    op_sel,
  rpn_ctrl_if.master    bus,
  output logic [DW-1:0] top,
  output logic          err,
  output logic          busy
);

  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_CNT   = CW'(2);
  localparam logic [TW-1:0] WAIT_LAST = TW'(ALU_TIMEOUT - 1);

  state_t        state;
  logic [DW-1:0] b_q;
  logic [1:0]    op_q;
  logic [TW-1:0] wait_cnt;
  logic          enter_evt;
  logic          op_evt;

  rpn_key_edge u_enter_edge (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .key_n (enter_n),
    .evt   (enter_evt)
  );

  rpn_key_edge u_op_edge (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .key_n (op_n),
    .evt   (op_evt)
  );

  assign busy = (state != IDLE);

  // Main sequencer: all strobes and datapath-facing values are registered.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the operand and ALU-facing registers are reset as well, so an
      // abort mid-operation leaves nothing stale on the outputs.
      state         <= IDLE;
      b_q           <= '0;
      op_q          <= OP_ADD;
      wait_cnt      <= '0;
      top           <= '0;
      err           <= 1'b0;
      bus.stk_push  <= 1'b0;
      bus.stk_pop   <= 1'b0;
      bus.stk_wdata <= '0;
      bus.alu_start <= 1'b0;
      bus.alu_op    <= 2'b00;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
    end else begin
      // Strobes default low so each one lasts exactly the cycle it is set for.
      bus.stk_push  <= 1'b0;
      bus.stk_pop   <= 1'b0;
      bus.alu_start <= 1'b0;

      case (state)
        IDLE: begin
          top <= (bus.stk_count != '0) ? bus.stk_rdata : '0;
          if (enter_evt) begin
            // ENTER has priority; a simultaneous OPERATE is dropped.
            if (bus.stk_count < DEPTH_CNT) begin
              bus.stk_push  <= 1'b1;
              bus.stk_wdata <= sw;
              err           <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end else if (op_evt) begin
            if (op_sel == OP_DROP) begin
              if (bus.stk_count != '0) begin
                bus.stk_pop <= 1'b1;
                err         <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end else if (bus.stk_count < TWO_CNT) begin
              err <= 1'b1;
            end else begin
              // Current top is operand b; pop it during POP_B.
              b_q         <= bus.stk_rdata;
              op_q        <= op_sel;
              bus.stk_pop <= 1'b1;
              state       <= POP_B;
            end
          end
        end

        POP_B: begin
          // The first pop lands at this edge; pop the deeper operand next.
          bus.stk_pop <= 1'b1;
          state       <= POP_A;
        end

        POP_A: begin
          // stk_rdata now shows operand a.
          bus.alu_a     <= bus.stk_rdata;
          bus.alu_b     <= b_q;
          bus.alu_op    <= op_q;
          bus.alu_start <= 1'b1;
          wait_cnt      <= '0;
          state         <= EXEC;
        end

        EXEC: begin
          state <= WAIT;
        end

        WAIT: begin
          if (bus.alu_done) begin
            bus.stk_push  <= 1'b1;
            bus.stk_wdata <= bus.alu_result;
            err           <= bus.alu_ovf;
            state         <= PUSH;
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end

        PUSH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_ctrl.sv
// Directed bench for rpn_ctrl with a behavioural stack and ALU.
module tb_rpn_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enter_n;
  logic       op_n;
  logic [7:0] sw;
  logic [1:0] op_sel;
  logic [7:0] top;
  logic       err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  rpn_ctrl_if #(.CW(4)) bus ();

  rpn_ctrl #(.DEPTH(8), .CW(4), .ALU_TIMEOUT(255)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .enter_n  (enter_n),
    .op_n     (op_n),
    .sw       (sw),
    .op_sel   (op_sel),
    .bus      (bus),
    .top      (top),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural 8-entry stack, reset by the same reset_n.
  logic [7:0] smem [0:7];
  logic [3:0] scnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scnt <= 4'd0;
    end else if (bus.stk_push && scnt < 4'd8) begin
      smem[scnt[2:0]] <= bus.stk_wdata;
      scnt            <= scnt + 4'd1;
    end else if (bus.stk_pop && scnt != 4'd0) begin
      scnt <= scnt - 4'd1;
    end
  end

  logic [3:0] sidx;
  assign sidx          = scnt - 4'd1;
  assign bus.stk_count = scnt;
  assign bus.stk_rdata = (scnt != 4'd0) ? smem[sidx[2:0]] : 8'h00;

  // Behavioural ALU: done arrives alu_lat cycles after start; 0 = never.
  int alu_lat = 1;
  int rem;
  bit pend;

  function automatic logic [8:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {(a < b), 8'(a - b)};
      2'b10:   return {(prod[15:8] != 8'h00), prod[7:0]};
      default: return 9'h000;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.alu_done   <= 1'b0;
      bus.alu_result <= 8'h00;
      bus.alu_ovf    <= 1'b0;
      pend           <= 1'b0;
      rem            <= 0;
    end else begin
      bus.alu_done <= 1'b0;
      if (bus.alu_start) begin
        {bus.alu_ovf, bus.alu_result} <= alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
        if (alu_lat == 1) begin
          bus.alu_done <= 1'b1;
        end else if (alu_lat > 1) begin
          pend <= 1'b1;
          rem  <= alu_lat - 1;
        end
      end else if (pend) begin
        if (rem == 1) begin
          bus.alu_done <= 1'b1;
          pend         <= 1'b0;
        end else begin
          rem <= rem - 1;
        end
      end
    end
  end

  // Event monitor: cumulative counts, tests compare deltas.
  int         push_cnt = 0;
  int         pop_cnt = 0;
  int         start_cnt = 0;
  int         busy_cyc = 0;
  int         overlap_cnt = 0;
  int         empty_pop_cnt = 0;
  logic [7:0] last_push = 8'h00;
  logic [7:0] pop_log [0:255];

  always @(posedge clk) begin
    if (bus.stk_push) begin
      push_cnt++;
      last_push = bus.stk_wdata;
    end
    if (bus.stk_pop) begin
      pop_log[pop_cnt[7:0]] = bus.stk_rdata;
      pop_cnt++;
      if (scnt == 4'd0) empty_pop_cnt++;
    end
    if (bus.alu_start) start_cnt++;
    if (busy === 1'b1) busy_cyc++;
    if (bus.stk_push && bus.stk_pop) overlap_cnt++;
  end

  task automatic do_reset();
    reset_n = 1'b0;
    enter_n = 1'b1;
    op_n    = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic press(input bit e, input bit o);
    @(negedge clk);
    enter_n = ~e;
    op_n    = ~o;
    repeat (8) @(negedge clk);
    enter_n = 1'b1;
    op_n    = 1'b1;
    wait_idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.stk_push, bus.stk_pop, bus.stk_wdata, bus.alu_start, bus.alu_op,
         bus.alu_a, bus.alu_b, top, err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: push=%b pop=%b wdata=%h start=%b op=%b a=%h b=%h top=%h err=%b busy=%b, required all 0",
               bus.stk_push, bus.stk_pop, bus.stk_wdata, bus.alu_start, bus.alu_op,
               bus.alu_a, bus.alu_b, top, err, busy);
    end
  endtask

  task automatic test_enter();
    int p0;
    int first;
    do_reset();
    p0    = push_cnt;
    sw    = 8'hAE;
    first = 0;
    @(negedge clk);
    enter_n = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.stk_push === 1'b1 && first == 0) first = k;
    end
    enter_n = 1'b1;
    wait_idle();
    repeat (4) @(negedge clk);
    checks++;
    if (first != 4) begin errors++; $display("FAIL enter_latency: push seen %0d cycles after press, required 4", first); end
    checks++;
    if (push_cnt - p0 != 1) begin errors++; $display("FAIL enter_push_count: got %0d, required 1", push_cnt - p0); end
    checks++;
    if (last_push !== 8'hAE) begin errors++; $display("FAIL enter_wdata: got %h, required ae", last_push); end
    checks++;
    if (top !== 8'hAE) begin errors++; $display("FAIL enter_top: got %h, required ae", top); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL enter_err: got %b, required 0", err); end
  endtask

  task automatic test_add_overflow();
    int p0, q0, s0, b0;
    do_reset();
    alu_lat = 1;
    sw = 8'hAE; press(1, 0);
    sw = 8'h83; press(1, 0);
    p0 = push_cnt; q0 = pop_cnt; s0 = start_cnt; b0 = busy_cyc;
    op_sel = 2'b00;
    press(0, 1);
    checks++;
    if (pop_cnt - q0 != 2) begin errors++; $display("FAIL add_pop_count: got %0d, required 2", pop_cnt - q0); end
    checks++;
    if (pop_log[q0[7:0]] !== 8'h83) begin errors++; $display("FAIL add_first_pop: got %h, required 83", pop_log[q0[7:0]]); end
    checks++;
    if (pop_log[8'(q0 + 1)] !== 8'hAE) begin errors++; $display("FAIL add_second_pop: got %h, required ae", pop_log[8'(q0 + 1)]); end
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL add_start_count: got %0d, required 1", start_cnt - s0); end
    checks++;
    if ({bus.alu_a, bus.alu_b} !== 16'hAE83) begin errors++; $display("FAIL add_operands: got a=%h b=%h, required a=ae b=83", bus.alu_a, bus.alu_b); end
    checks++;
    if (push_cnt - p0 != 1 || last_push !== 8'h31) begin errors++; $display("FAIL add_result: got %0d pushes last %h, required 1 push of 31", push_cnt - p0, last_push); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL add_overflow_err: got %b, required 1", err); end
    checks++;
    if (busy_cyc - b0 != 5) begin errors++; $display("FAIL add_busy_cycles: got %0d, required 5", busy_cyc - b0); end
    checks++;
    if (top !== 8'h31 || bus.stk_count !== 4'd1) begin errors++; $display("FAIL add_top: got top=%h count=%0d, required 31 and 1", top, bus.stk_count); end
  endtask

  task automatic test_sub_slow_alu();
    int p0, s0, b0;
    do_reset();
    alu_lat = 3;
    sw = 8'h83; press(1, 0);
    sw = 8'h03; press(1, 0);
    p0 = push_cnt; s0 = start_cnt; b0 = busy_cyc;
    op_sel = 2'b01;
    sw     = 8'h55;
    @(negedge clk);
    op_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL sub_busy_started: got %b, required 1", busy); end
    enter_n = 1'b0;
    repeat (8) @(negedge clk);
    op_n    = 1'b1;
    enter_n = 1'b1;
    wait_idle();
    repeat (4) @(negedge clk);
    checks++;
    if (push_cnt - p0 != 1 || last_push !== 8'h80) begin errors++; $display("FAIL sub_result: got %0d pushes last %h, required 1 push of 80", push_cnt - p0, last_push); end
    checks++;
    if (busy_cyc - b0 != 7) begin errors++; $display("FAIL sub_busy_cycles: got %0d, required 7", busy_cyc - b0); end
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL sub_start_count: got %0d, required 1", start_cnt - s0); end
    checks++;
    if (err !== 1'b0 || top !== 8'h80) begin errors++; $display("FAIL sub_state: got err=%b top=%h, required 0 and 80", err, top); end
    // Multiply wrapping to zero flags overflow.
    sw = 8'h02; press(1, 0);
    op_sel = 2'b10;
    press(0, 1);
    checks++;
    if (last_push !== 8'h00 || err !== 1'b1) begin errors++; $display("FAIL mul_overflow: got %h err=%b, required 00 err=1", last_push, err); end
  endtask

  task automatic test_empty_operate();
    int p0, q0, s0;
    do_reset();
    alu_lat = 1;
    q0 = pop_cnt; s0 = start_cnt;
    op_sel = 2'b00;
    press(0, 1);
    checks++;
    if (pop_cnt - q0 != 0 || start_cnt - s0 != 0) begin errors++; $display("FAIL empty_no_action: got %0d pops %0d starts, required 0 and 0", pop_cnt - q0, start_cnt - s0); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL empty_err: got %b, required 1", err); end
    p0 = push_cnt;
    sw = 8'h01;
    press(1, 0);
    checks++;
    if (push_cnt - p0 != 1 || last_push !== 8'h01) begin errors++; $display("FAIL empty_then_enter: got %0d pushes last %h, required 1 push of 01", push_cnt - p0, last_push); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL empty_err_clear: got %b, required 0", err); end
  endtask

  task automatic test_full_and_drop();
    int p0, q0;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      sw = 8'(i);
      press(1, 0);
    end
    checks++;
    if (bus.stk_count !== 4'd8 || top !== 8'h08 || err !== 1'b0) begin errors++; $display("FAIL full_fill: got count=%0d top=%h err=%b, required 8 08 0", bus.stk_count, top, err); end
    p0 = push_cnt;
    sw = 8'h99;
    press(1, 0);
    checks++;
    if (push_cnt - p0 != 0) begin errors++; $display("FAIL full_no_push: got %0d pushes, required 0", push_cnt - p0); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL full_err: got %b, required 1", err); end
    q0 = pop_cnt;
    op_sel = 2'b11;
    press(0, 1);
    checks++;
    if (pop_cnt - q0 != 1) begin errors++; $display("FAIL drop_pop_count: got %0d, required 1", pop_cnt - q0); end
    checks++;
    if (err !== 1'b0 || top !== 8'h07 || bus.stk_count !== 4'd7) begin errors++; $display("FAIL drop_state: got err=%b top=%h count=%0d, required 0 07 7", err, top, bus.stk_count); end
  endtask

  task automatic test_alu_timeout();
    int p0, q0, s0, b0;
    do_reset();
    alu_lat = 0;
    sw = 8'h05; press(1, 0);
    sw = 8'h06; press(1, 0);
    p0 = push_cnt; q0 = pop_cnt; s0 = start_cnt; b0 = busy_cyc;
    op_sel = 2'b00;
    press(0, 1);
    checks++;
    if (busy_cyc - b0 != 258) begin errors++; $display("FAIL timeout_busy_cycles: got %0d, required 258", busy_cyc - b0); end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_state: got err=%b busy=%b, required 1 0", err, busy); end
    checks++;
    if (push_cnt - p0 != 0 || pop_cnt - q0 != 2 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL timeout_strobes: got push=%0d pop=%0d start=%0d, required 0 2 1", push_cnt - p0, pop_cnt - q0, start_cnt - s0);
    end
    checks++;
    if (bus.stk_count !== 4'd0 || top !== 8'h00) begin errors++; $display("FAIL timeout_stack: got count=%0d top=%h, required 0 00", bus.stk_count, top); end
  endtask

  task automatic test_reset_in_wait();
    int p0, q0, s0;
    do_reset();
    alu_lat = 0;
    sw = 8'h11; press(1, 0);
    sw = 8'h22; press(1, 0);
    op_sel = 2'b00;
    @(negedge clk);
    op_n = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.alu_a !== 8'h11) begin errors++; $display("FAIL wait_reached: got busy=%b a=%h, required 1 11", busy, bus.alu_a); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.stk_push, bus.stk_pop, bus.stk_wdata, bus.alu_start, bus.alu_op,
         bus.alu_a, bus.alu_b, top, err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: push=%b pop=%b wdata=%h start=%b op=%b a=%h b=%h top=%h err=%b busy=%b, required all 0",
               bus.stk_push, bus.stk_pop, bus.stk_wdata, bus.alu_start, bus.alu_op,
               bus.alu_a, bus.alu_b, top, err, busy);
    end
    p0 = push_cnt; q0 = pop_cnt; s0 = start_cnt;
    op_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (push_cnt - p0 != 0 || pop_cnt - q0 != 0 || start_cnt - s0 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_strobes: got push=%0d pop=%0d start=%0d busy=%b, required 0 0 0 0", push_cnt - p0, pop_cnt - q0, start_cnt - s0, busy);
    end
  endtask

  task automatic test_enter_op_same_cycle();
    int p0, q0, s0, b0;
    do_reset();
    alu_lat = 1;
    sw = 8'h10; press(1, 0);
    sw = 8'h20; press(1, 0);
    p0 = push_cnt; q0 = pop_cnt; s0 = start_cnt; b0 = busy_cyc;
    op_sel = 2'b00;
    sw     = 8'h30;
    press(1, 1);
    checks++;
    if (push_cnt - p0 != 1 || last_push !== 8'h30) begin errors++; $display("FAIL both_push: got %0d pushes last %h, required 1 push of 30", push_cnt - p0, last_push); end
    checks++;
    if (pop_cnt - q0 != 0 || start_cnt - s0 != 0 || busy_cyc - b0 != 0) begin
      errors++;
      $display("FAIL both_op_dropped: got pop=%0d start=%0d busy=%0d, required 0 0 0", pop_cnt - q0, start_cnt - s0, busy_cyc - b0);
    end
    checks++;
    if (top !== 8'h30 || bus.stk_count !== 4'd3) begin errors++; $display("FAIL both_top: got top=%h count=%0d, required 30 3", top, bus.stk_count); end
  endtask

  initial begin
    reset_n = 1'b0;
    enter_n = 1'b1;
    op_n    = 1'b1;
    sw      = 8'h00;
    op_sel  = 2'b00;
    test_reset();
    test_enter();
    test_add_overflow();
    test_sub_slow_alu();
    test_empty_operate();
    test_full_and_drop();
    test_alu_timeout();
    test_reset_in_wait();
    test_enter_op_same_cycle();
    checks++;
    if (overlap_cnt != 0 || empty_pop_cnt != 0) begin
      errors++;
      $display("FAIL stack_rules: got %0d push+pop overlaps and %0d pops on empty, required 0 0", overlap_cnt, empty_pop_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
